ppu_spr_render: RTL and testbench

Per-pixel sprite rendering and priority mux for the PPU, directly downstream of sprite evaluation and pattern fetch. Accepts up to eight fetched sprites (pattern low/high bytes, attribute byte, X position) into a staging set during HBlank, commits them at line start, and then produces one 5-bit palette RAM address per visible pixel. The address selects between the background pixel and the highest-priority opaque sprite pixel. Also generates the sticky sprite-0-hit flag.

---
 rtl/ppu_pkg.sv | 35 +++
 rtl/ppu_spr_render_if.sv | 22 ++
 rtl/ppu_spr_slot.sv | 42 ++++
 rtl/ppu_spr_render.sv | 154 +++++++++++++++
 tb/tb_ppu_spr_render.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU sprite-rendering types and constants.
// Slots hold pattern bytes already flipped, so shifters always run MSB-first.
package ppu_pkg;

  localparam int ATTR_PAL   = 0;   // LSB of the 2-bit palette field
  localparam int ATTR_PRIO  = 5;
  localparam int ATTR_FLIPH = 6;
  localparam int VISIBLE_W  = 256;

  typedef struct packed {
    logic [7:0] pat_lo;
    logic [7:0] pat_hi;
    logic [7:0] attr;
    logic [7:0] x;
    logic       zero;
  } spr_slot_t;

  // Empty slot: transparent pattern, parked at the far right.
  localparam spr_slot_t SLOT_EMPTY = '{
    pat_lo: 8'h00,
    pat_hi: 8'h00,
    attr:   8'h00,
    x:      8'hFF,
    zero:   1'b0
  };

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ppu_spr_render_if.sv
// Sprite load bus from the pattern-fetch stage into the renderer staging set.
interface ppu_spr_render_if;

  logic       load_en;
  logic [2:0] load_slot;
  logic [7:0] load_pat_lo;
  logic [7:0] load_pat_hi;
  logic [7:0] load_attr;
  logic [7:0] load_x;
  logic       load_zero;

  modport master (
    output load_en, load_slot, load_pat_lo, load_pat_hi,
           load_attr, load_x, load_zero
  );

  modport slave (
    input  load_en, load_slot, load_pat_lo, load_pat_hi,
           load_attr, load_x, load_zero
  );

endinterface

// File: rtl/ppu_spr_slot.sv
// One active sprite slot: X down-counter plus two MSB-first pattern shifters.
module ppu_spr_slot
  import ppu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      commit,
  input  spr_slot_t commit_data,
  input  logic      tick,
  output logic [1:0] px,
  output logic [1:0] pal,
  output logic       prio,
  output logic       zero
);

  spr_slot_t slot_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_reg <= SLOT_EMPTY;
    end else if (commit) begin
      slot_reg <= commit_data;
    end else if (tick) begin
      if (slot_reg.x != 8'd0) begin
        slot_reg.x <= slot_reg.x - 8'd1;
      end else begin
        slot_reg.pat_lo <= {slot_reg.pat_lo[6:0], 1'b0};
        slot_reg.pat_hi <= {slot_reg.pat_hi[6:0], 1'b0};
      end
    end
  end

  // The pixel only exists once the counter has reached the sprite's column.
  assign px   = (slot_reg.x == 8'd0) ? {slot_reg.pat_hi[7], slot_reg.pat_lo[7]} : 2'b00;
  assign pal  = slot_reg.attr[ATTR_PAL +: 2];
  assign prio = slot_reg.attr[ATTR_PRIO];
  assign zero = slot_reg.zero;

  logic attr_unused;
  assign attr_unused = ^{slot_reg.attr[7:6], slot_reg.attr[4:2]};

endmodule

// File: rtl/ppu_spr_render.sv
// Sprite staging/commit, per-pixel priority encoder, background mux and
// sticky sprite-0 hit flag.
module ppu_spr_render
  import ppu_pkg::*;
#(
  parameter int N_SLOTS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixel_tick,
  input  logic [9:0]             DrawX,
  input  logic                   line_start,
  ppu_spr_render_if.slave        ld,
  input  logic                   spr_en,
  input  logic [3:0]             bg_px,
  input  logic                   clear_hit,
  output logic [4:0]             color_code,
  output logic                   priority_bit,
  output logic                   spr0_hit
);

  spr_slot_t stage_reg [N_SLOTS];
  spr_slot_t load_entry;

  logic       visible;
  logic       px_tick;
  logic       bg_opaque;

  logic [1:0]         slot_px  [N_SLOTS];
  logic [1:0]         slot_pal [N_SLOTS];
  logic [N_SLOTS-1:0] slot_prio;
  logic [N_SLOTS-1:0] slot_zero;
  logic [N_SLOTS-1:0] slot_opaque;
  logic [N_SLOTS-1:0] slot_vis;

  logic       win_found;
  logic [1:0] win_px;
  logic [1:0] win_pal;
  logic       win_prio;
  logic       hit_now;

  logic [4:0] cc_reg, cc_next;
  logic       prio_reg, prio_next;
  logic       hit_reg;

  assign visible   = (DrawX < 10'(VISIBLE_W));
  // A tick coinciding with line_start is swallowed by the commit.
  assign px_tick   = pixel_tick && visible && !line_start;
  assign bg_opaque = (bg_px[1:0] != 2'b00);

  always_comb begin
    load_entry.attr   = ld.load_attr;
    load_entry.x      = ld.load_x;
    load_entry.zero   = ld.load_zero;
    load_entry.pat_lo = ld.load_pat_lo;
    load_entry.pat_hi = ld.load_pat_hi;
    if (ld.load_attr[ATTR_FLIPH]) begin
      load_entry.pat_lo = bit_rev8(ld.load_pat_lo);
      load_entry.pat_hi = bit_rev8(ld.load_pat_hi);
    end
  end

  // Clear-on-commit first, then the load, so a same-cycle load survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        stage_reg[i] <= SLOT_EMPTY;
      end
    end else begin
      if (line_start) begin
        for (int i = 0; i < N_SLOTS; i++) begin
          stage_reg[i] <= SLOT_EMPTY;
        end
      end
      if (ld.load_en) begin
        stage_reg[ld.load_slot] <= load_entry;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      ppu_spr_slot u_slot (
        .clk         (clk),
        .reset       (reset),
        .commit      (line_start),
        .commit_data (stage_reg[gi]),
        .tick        (px_tick),
        .px          (slot_px[gi]),
        .pal         (slot_pal[gi]),
        .prio        (slot_prio[gi]),
        .zero        (slot_zero[gi])
      );
      assign slot_opaque[gi] = (slot_px[gi] != 2'b00);
    end
  endgenerate

  assign slot_vis = slot_opaque & {N_SLOTS{spr_en}};

  // Scan high to low so the lowest-index opaque slot is the last to win.
  always_comb begin
    win_found = 1'b0;
    win_px    = 2'b00;
    win_pal   = 2'b00;
    win_prio  = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (slot_vis[i]) begin
        win_found = 1'b1;
        win_px    = slot_px[i];
        win_pal   = slot_pal[i];
        win_prio  = slot_prio[i];
      end
    end
  end

  always_comb begin
    cc_next   = 5'h00;
    prio_next = 1'b0;
    if (win_found && (!win_prio || !bg_opaque)) begin
      cc_next   = {1'b1, win_pal, win_px};
      prio_next = 1'b1;
    end else if (bg_opaque) begin
      cc_next   = {1'b0, bg_px};
      prio_next = 1'b0;
    end
  end

  // Any opaque sprite-0 pixel counts, even when a lower slot wins the mux.
  assign hit_now = spr_en && |(slot_vis & slot_zero) && bg_opaque &&
                   (DrawX != 10'(VISIBLE_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cc_reg   <= 5'h00;
      prio_reg <= 1'b0;
    end else if (px_tick) begin
      cc_reg   <= cc_next;
      prio_reg <= prio_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_hit) begin
      hit_reg <= 1'b0;
    end else if (px_tick && hit_now) begin
      hit_reg <= 1'b1;
    end
  end

  assign color_code   = cc_reg;
  assign priority_bit = prio_reg;
  assign spr0_hit     = hit_reg;

endmodule

// File: tb/tb_ppu_spr_render.sv
// Directed bench for ppu_spr_render: renders whole scanlines and checks
// hand-computed palette addresses, priority and sprite-0 hit at key columns.
module tb_ppu_spr_render;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_tick;
  logic [9:0] DrawX;
  logic       line_start;
  logic       spr_en;
  logic [3:0] bg_px;
  logic       clear_hit;
  logic [4:0] color_code;
  logic       priority_bit;
  logic       spr0_hit;

  ppu_spr_render_if ld_if ();

  ppu_spr_render #(.N_SLOTS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_tick   (pixel_tick),
    .DrawX        (DrawX),
    .line_start   (line_start),
    .ld           (ld_if),
    .spr_en       (spr_en),
    .bg_px        (bg_px),
    .clear_hit    (clear_hit),
    .color_code   (color_code),
    .priority_bit (priority_bit),
    .spr0_hit     (spr0_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] obs_cc  [256];
  logic       obs_pr  [256];
  logic       obs_hit [256];
  logic [3:0] bg_line [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_bg();
    for (int n = 0; n < 256; n++) bg_line[n] = 4'h0;
  endtask

  task automatic put_load(input logic [2:0] slot, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] attr, input logic [7:0] x, input logic zero);
    ld_if.load_slot   = slot;
    ld_if.load_pat_lo = lo;
    ld_if.load_pat_hi = hi;
    ld_if.load_attr   = attr;
    ld_if.load_x      = x;
    ld_if.load_zero   = zero;
  endtask

  task automatic load(input logic [2:0] slot, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [7:0] attr, input logic [7:0] x, input logic zero);
    @(negedge clk);
    put_load(slot, lo, hi, attr, x, zero);
    ld_if.load_en = 1'b1;
    @(negedge clk);
    ld_if.load_en = 1'b0;
  endtask

  // Commit, then tick through all 256 visible columns recording outputs.
  task automatic run_line(input bit with_load);
    @(negedge clk);
    line_start = 1'b1;
    if (with_load) ld_if.load_en = 1'b1;
    @(negedge clk);
    line_start    = 1'b0;
    ld_if.load_en = 1'b0;
    for (int n = 0; n < 256; n++) begin
      DrawX      = 10'(n);
      bg_px      = bg_line[n];
      pixel_tick = 1'b1;
      @(negedge clk);
      obs_cc[n]  = color_code;
      obs_pr[n]  = priority_bit;
      obs_hit[n] = spr0_hit;
    end
    pixel_tick = 1'b0;
    DrawX      = 10'd300;
    bg_px      = 4'h0;
    $display("line rendered");
  endtask

  task automatic check_quiet(input string tag, input int lo, input int hi);
    int cnt;
    cnt = 0;
    for (int n = 0; n < 256; n++) begin
      if ((n < lo || n > hi) && obs_cc[n] != 5'h00) cnt++;
    end
    check(tag, 32'(cnt), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    pixel_tick    = 1'b0;
    DrawX         = 10'd300;
    line_start    = 1'b0;
    spr_en        = 1'b1;
    bg_px         = 4'h0;
    clear_hit     = 1'b0;
    ld_if.load_en = 1'b0;
    put_load(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    clear_bg();
    repeat (3) @(negedge clk);
    check("reset_cc",   32'(color_code),   32'h00);
    check("reset_prio", 32'(priority_bit), 32'h0);
    check("reset_hit",  32'(spr0_hit),     32'h0);
    reset = 1'b0;

    // Single sprite
    load(3'd0, 8'h80, 8'h80, 8'h01, 8'd10, 1'b0);
    run_line(0);
    check("single_x10",  32'(obs_cc[10]), 32'h17);
    check("single_pr10", 32'(obs_pr[10]), 32'h1);
    check("single_x9",   32'(obs_cc[9]),  32'h00);
    check("single_x11",  32'(obs_cc[11]), 32'h00);
    check_quiet("single_elsewhere", 10, 10);

    // Horizontal flip
    load(3'd0, 8'h01, 8'h00, 8'h40, 8'd20, 1'b0);
    run_line(0);
    check("flip_x20", 32'(obs_cc[20]), 32'h11);
    check("flip_x27", 32'(obs_cc[27]), 32'h00);
    load(3'd0, 8'h01, 8'h00, 8'h00, 8'd20, 1'b0);
    run_line(0);
    check("noflip_x20", 32'(obs_cc[20]), 32'h00);
    check("noflip_x27", 32'(obs_cc[27]), 32'h11);
    check_quiet("noflip_elsewhere", 27, 27);

    // Overlap: lower slot wins
    load(3'd2, 8'hFF, 8'h00, 8'h02, 8'd30, 1'b0);
    load(3'd5, 8'hFF, 8'hFF, 8'h03, 8'd30, 1'b0);
    run_line(0);
    check("overlap_slot2_x30", 32'(obs_cc[30]), 32'h19);
    check("overlap_slot2_x37", 32'(obs_cc[37]), 32'h19);
    load(3'd2, 8'h00, 8'h00, 8'h02, 8'd30, 1'b0);
    load(3'd5, 8'hFF, 8'hFF, 8'h03, 8'd30, 1'b0);
    run_line(0);
    check("overlap_slot5_x30", 32'(obs_cc[30]), 32'h1F);

    // Behind-background priority
    load(3'd0, 8'hFF, 8'h00, 8'h21, 8'd50, 1'b0);
    bg_line[50] = 4'h6;
    bg_line[51] = 4'h4;
    run_line(0);
    check("prio_bg_cc",    32'(obs_cc[50]), 32'h06);
    check("prio_bg_pr",    32'(obs_pr[50]), 32'h0);
    check("prio_spr_cc",   32'(obs_cc[51]), 32'h15);
    check("prio_spr_pr",   32'(obs_pr[51]), 32'h1);
    check("prio_nobg_cc",  32'(obs_cc[52]), 32'h15);
    clear_bg();

    // Sprite-0 hit
    load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd100, 1'b1);
    bg_line[100] = 4'h5;
    run_line(0);
    check("hit_cc_x100",  32'(obs_cc[100]),  32'h11);
    check("hit_x99",      32'(obs_hit[99]),  32'h0);
    check("hit_x100",     32'(obs_hit[100]), 32'h1);
    check("hit_x255",     32'(obs_hit[255]), 32'h1);
    clear_bg();
    run_line(0);
    check("hit_sticky", 32'(obs_hit[0]), 32'h1);
    @(negedge clk);
    clear_hit = 1'b1;
    @(negedge clk);
    clear_hit = 1'b0;
    check("hit_cleared", 32'(spr0_hit), 32'h0);

    // No hit at column 255; output holds through HBlank
    load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd255, 1'b1);
    bg_line[255] = 4'h5;
    run_line(0);
    check("edge_cc_x255",  32'(obs_cc[255]),  32'h11);
    check("edge_nohit",    32'(obs_hit[255]), 32'h0);
    clear_bg();
    pixel_tick = 1'b1;
    DrawX      = 10'd300;
    repeat (2) @(negedge clk);
    pixel_tick = 1'b0;
    check("hold_cc", 32'(color_code),   32'h11);
    check("hold_pr", 32'(priority_bit), 32'h1);

    // Hit from a non-winning sprite 0
    load(3'd0, 8'hFF, 8'h00, 8'h02, 8'd120, 1'b0);
    load(3'd1, 8'hFF, 8'h00, 8'h01, 8'd120, 1'b1);
    bg_line[120] = 4'h1;
    run_line(0);
    check("nonwin_cc",    32'(obs_cc[120]),  32'h19);
    check("nonwin_x119",  32'(obs_hit[119]), 32'h0);
    check("nonwin_x120",  32'(obs_hit[120]), 32'h1);
    clear_bg();

    // Commit clears staging
    load(3'd3, 8'hFF, 8'hFF, 8'h00, 8'd60, 1'b0);
    run_line(0);
    check("commit_lineA1", 32'(obs_cc[60]), 32'h13);
    run_line(0);
    check("commit_lineA2", 32'(obs_cc[60]), 32'h00);

    // Load coincident with line_start lands one line later
    put_load(3'd1, 8'hFF, 8'h00, 8'h01, 8'd70, 1'b0);
    run_line(1);
    check("ls_load_same",  32'(obs_cc[70]), 32'h00);
    run_line(0);
    check("ls_load_next",  32'(obs_cc[70]), 32'h15);
    run_line(0);
    check("ls_load_after", 32'(obs_cc[70]), 32'h00);

    // Sprites disabled: background only
    spr_en = 1'b0;
    load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd10, 1'b0);
    bg_line[10] = 4'h1;
    run_line(0);
    check("spr_off_cc", 32'(obs_cc[10]), 32'h01);
    check("spr_off_pr", 32'(obs_pr[10]), 32'h0);
    spr_en = 1'b1;
    clear_bg();

    // Reset flushes staging and the hit flag
    load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd40, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_hit", 32'(spr0_hit), 32'h0);
    run_line(0);
    check_quiet("rst_staging", 256, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
